apb4_regfile_slv_param: RTL
===========================

Name: apb4_regfile_slv_param

Overview:
- Parametrised APB4 completer register file; next generation of the team's fixed 16-register slave.
- Adds configurable register count and base address, programmable wait states, and per-register read-only (hardware-driven) registers.
- Adds PPROT write protection, out-of-range error, and a flattened register output bus for downstream logic.
- Sits behind the APB decoder on one PSEL line.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
ADDR_WIDTH, 32, address bus width.
NUM_REGS, 16, number of 32-bit-aligned registers; 1..256.
BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8.
WAIT_STATES, 0, extra access-phase cycles before PREADY; 0..15.
RO_MASK, 0, NUM_REGS bits; bit i=1 makes register i read-only, sourced from hw_ro_in.
PROT_CHECK, 1, 1 = writes require PPROT[0]=1 (privileged).

Ports:
PCLK  in  1  clock, rising edge.
PRESETn  in  1  reset, asynchronous, active-low.
PADDR  in  ADDR_WIDTH  byte address.
PSEL  in  1  select.
PENABLE  in  1  access phase.
PWRITE  in  1  1 = write.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  byte lane strobes.
PPROT  in  3  protection attributes.
PREADY  out  1  registered transfer complete.
PRDATA  out  DATA_WIDTH  registered read data.
PSLVERR  out  1  registered error, valid only with PREADY.
hw_ro_in  in  NUM_REGS*DATA_WIDTH  value returned for RO registers; slice i = register i.
regs_out  out  NUM_REGS*DATA_WIDTH  current RW register contents; RO slices drive 0.

Behaviour:
- Reset (async assert, sync release): PREADY=0, PRDATA=0, PSLVERR=0, all RW registers=0, FSM=IDLE, wait counter=0.
- FSM states:
  - IDLE: on an edge sampling PSEL&PENABLE:
    - WAIT_STATES=0 -> RESP.
    - Otherwise -> WAIT, cnt=WAIT_STATES-1.
  - WAIT: if PSEL=0, abort -> IDLE with no commit and outputs unchanged. Else if cnt=0 -> RESP; else cnt-1.
  - RESP: PREADY=1 for exactly one cycle. Next edge: PREADY=0, PRDATA=0, PSLVERR=0 -> IDLE.
- On entry to RESP (same edge), the transfer is decoded and committed; PRDATA/PSLVERR are registered alongside PREADY=1.
- Timing: PREADY is high in access cycle WAIT_STATES+2, counting the first PENABLE cycle as 1. Back-to-back transfers are accepted from IDLE immediately.
- Decode: off = PADDR-BASE_ADDR; idx = off/(DATA_WIDTH/8).
- Error (PSLVERR=1, no register update, PRDATA=0) when any of:
  - PADDR not aligned to DATA_WIDTH/8.
  - PADDR < BASE_ADDR, or idx >= NUM_REGS.
  - Write to a register with RO_MASK[idx]=1.
  - PROT_CHECK=1 and write with PPROT[0]=0.
- Valid write: byte lane b of reg[idx] takes PWDATA lane b when PSTRB[b]=1, else keeps its value. PSTRB=0 is legal, leaves the register unchanged, PSLVERR=0.
- Valid read: PRDATA = reg[idx], or hw_ro_in slice idx if RO, sampled at the RESP-entry edge. PSTRB and PPROT are ignored on reads.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT are sampled at the RESP-entry edge; the master holds them stable per APB.
- regs_out reflects the write from the edge after commit.
- Reset mid-transfer: immediate return to reset values; the pending write is lost.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to reg 3 (PSTRB=0xF, PPROT=3'b001), then read -> PREADY in 2nd access cycle; PRDATA=0xDEADBEEF; PSLVERR=0; regs_out slice 3 = 0xDEADBEEF.
- Partial strobe: reg 3=0xDEADBEEF; write 0x11223344 with PSTRB=4'b0101 -> read 0xDE22BE44.
- WAIT_STATES=3: any read -> PREADY low for 4 access cycles, high in the 5th for one cycle; PSEL dropped in a WAIT cycle -> no PREADY, no write.
- Errors, each giving PSLVERR=1, PRDATA=0, contents unchanged:
  - Address 0x2 (misaligned).
  - Address NUM_REGS*4 (out of range).
  - Write to RO reg with RO_MASK bit set.
  - Write with PPROT=3'b000.
- RO read: hw_ro_in slice 5=0xA5A5_0001, RO_MASK[5]=1 -> read reg 5 returns 0xA5A50001; BASE_ADDR=0x100: read 0x100 hits reg 0, read 0x0FC -> PSLVERR.
- Assert PRESETn low during WAIT of a write -> PREADY/PRDATA/PSLVERR 0 immediately; register remains 0 after release.

Source files
------------

// File: rtl/apb4_regfile_slv_param.sv
// rtl/apb4_regfile_slv_param.sv - parametrised APB4 completer register file with wait states, RO registers and PPROT checking
`timescale 1ns/1ps
module apb4_regfile_slv_param #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter bit                    PROT_CHECK  = 1'b1
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [2:0]                     PPROT,
  output logic                           PREADY,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                         state;
  logic [3:0]                     cnt;
  logic [NUM_REGS*DATA_WIDTH-1:0] reg_q;

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  prot_bad;
  logic                  is_ro;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  enter_resp;

  // Address decode relative to the block's base; index is in whole registers
  assign off          = PADDR - BASE_ADDR;
  assign idx_full     = off / ADDR_WIDTH'(NBYTES);
  assign idx          = idx_full[IDX_W-1:0];
  assign misaligned   = (PADDR % ADDR_WIDTH'(NBYTES)) != '0;
  assign out_of_range = (PADDR < BASE_ADDR) || (idx_full >= ADDR_WIDTH'(NUM_REGS));
  assign prot_bad     = PROT_CHECK && PWRITE && !PPROT[0];

  // Read mux and RO lookup; only meaningful when the index is in range
  always_comb begin
    is_ro  = 1'b0;
    rd_val = '0;
    if (!out_of_range) begin
      is_ro  = RO_MASK[idx];
      rd_val = is_ro ? hw_ro_in[int'(idx)*DATA_WIDTH +: DATA_WIDTH]
                     : reg_q[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign acc_err = misaligned || out_of_range || (PWRITE && is_ro) || prot_bad;

  // The edge that moves the FSM into RESP is also the commit edge
  always_comb begin
    enter_resp = 1'b0;
    case (state)
      S_IDLE:  enter_resp = PSEL && PENABLE && (WAIT_STATES == 0);
      S_WAIT:  enter_resp = PSEL && (cnt == 4'd0);
      default: enter_resp = 1'b0;
    endcase
  end

  // Transfer FSM with registered PREADY/PRDATA/PSLVERR
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else if (enter_resp) begin
      state   <= S_RESP;
      PREADY  <= 1'b1;
      PSLVERR <= acc_err;
      PRDATA  <= (acc_err || PWRITE) ? '0 : rd_val;
    end else begin
      case (state)
        S_IDLE: begin
          if (PSEL && PENABLE) begin
            state <= S_WAIT;
            cnt   <= WS_INIT;
          end
        end
        S_WAIT: begin
          // Master withdrew the transfer: drop it without committing
          if (!PSEL) state <= S_IDLE;
          else       cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PRDATA  <= '0;
          PSLVERR <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane register update; RO slices are never written and stay 0
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      reg_q <= '0;
    end else if (enter_resp && PWRITE && !acc_err) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (PSTRB[b]) reg_q[int'(idx)*DATA_WIDTH + b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

  assign regs_out = reg_q;

  logic unused_bits;
  assign unused_bits = ^{PPROT[2:1], off, idx_full};

endmodule
